maxpool2x2_stream: RTL



---
 rtl/maxpool2x2_stream.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 signed max-pooling stage
//
// Purpose: pools a pixel-serial, row-major IMG_W x IMG_H feature map into an
// OUT_W x OUT_H map (OUT_W = IMG_W/2, OUT_H = IMG_H/2, floored). Only a
// half-row line buffer (OUT_W entries) is kept. An odd trailing column or
// row is consumed but never pooled.
//
// Optional feature: define MAXPOOL_RELU_EN to fuse a ReLU into the vertical
// compare stage. Negative pooled results are then output as zero.
//
// Ports:
//   cnn_clk    in   clock, rising edge
//   cnn_rst    in   synchronous reset, active high
//   in_valid   in   in_data carries a pixel this cycle (always accepted)
//   in_data    in   DATA_W signed input pixel
//   out_valid  out  out_data carries a pooled pixel
//   out_data   out  DATA_W signed pooled pixel
//   out_last   out  high with the final pooled pixel of a frame
//   frame_done out  one-cycle pulse after the last input pixel of a frame
module maxpool2x2_stream #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 20
) (
    input  logic              cnn_clk,
    input  logic              cnn_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam bit W_ODD = (IMG_W % 2) == 1;
    localparam bit H_ODD = (IMG_H % 2) == 1;

    localparam logic [CW-1:0] COL_MAX     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX     = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LASTWIN = CW'(2 * OUT_W - 1);
    localparam logic [RW-1:0] ROW_LASTWIN = RW'(2 * OUT_H - 1);

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] post(input logic [DATA_W-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // position counters
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    // stage 1: horizontal pair
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pair_valid_q, pair_valid_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic              pair_odd_q, pair_odd_d;
    logic [IW-1:0]     pair_idx_q, pair_idx_d;
    logic              pair_last_q, pair_last_d;
    // stage 2: vertical compare / output
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;

    logic [DATA_W-1:0] linebuf_q [OUT_W];
    logic [DATA_W-1:0] lb_rd;
    logic              lb_we;

    logic at_col_end, at_row_end, row_pooled, even_col_pooled;

    always_comb begin
        at_col_end      = (col_q == COL_MAX);
        at_row_end      = (row_q == ROW_MAX);
        // The trailing row/column of an odd dimension never joins a window.
        row_pooled      = !H_ODD || !at_row_end;
        even_col_pooled = !col_q[0] && (!W_ODD || !at_col_end);
        lb_we           = pair_valid_q && !pair_odd_q;
        lb_rd           = linebuf_q[pair_idx_q];
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        pair_valid_d = 1'b0;
        pair_d       = pair_q;
        pair_odd_d   = pair_odd_q;
        pair_idx_d   = pair_idx_q;
        pair_last_d  = pair_last_q;
        frame_done_d = 1'b0;

        if (in_valid) begin
            if (at_col_end) begin
                col_d = '0;
                row_d = at_row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (even_col_pooled) begin
                hold_d = in_data;
            end

            // Odd columns always have an even partner to their left.
            if (col_q[0] && row_pooled) begin
                pair_valid_d = 1'b1;
                pair_d       = smax(hold_q, in_data);
                pair_odd_d   = row_q[0];
                pair_idx_d   = IW'(col_q >> 1);
                pair_last_d  = (row_q == ROW_LASTWIN) && (col_q == COL_LASTWIN);
            end

            frame_done_d = at_col_end && at_row_end;
        end

        // Even-row pairs go to the line buffer; odd-row pairs read the same
        // entry, so a single entry is never read and written together.
        out_valid_d = pair_valid_q && pair_odd_q;
        out_last_d  = out_valid_d && pair_last_q;
        out_data_d  = out_valid_d ? post(smax(lb_rd, pair_q)) : out_data_q;
    end

    always_ff @(posedge cnn_clk) begin
        if (cnn_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            pair_valid_q <= 1'b0;
            pair_q       <= '0;
            pair_odd_q   <= 1'b0;
            pair_idx_q   <= '0;
            pair_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            pair_valid_q <= pair_valid_d;
            pair_q       <= pair_d;
            pair_odd_q   <= pair_odd_d;
            pair_idx_q   <= pair_idx_d;
            pair_last_q  <= pair_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer has no reset: every entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge cnn_clk) begin
        if (lb_we) begin
            linebuf_q[pair_idx_q] <= pair_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule
